// File: rtl/bullet_pkg.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Package  : bullet_pkg
// Brief    : Shared constants, FSM encoding and requester IDs for bullet firing.
// Revision : 1.0  initial release
//==============================================================================
package bullet_pkg;

   localparam logic       DIR_UP   = 1'b1;
   localparam logic       DIR_DOWN = 1'b0;
   localparam logic [9:0] SPAWN_Y  = 10'd240;
   localparam logic [9:0] SCREEN_H = 10'd480;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CONFIRM = 2'd2
   } fire_state_t;

   typedef enum logic {
      REQ_PLAYER = 1'b0,
      REQ_ENEMY  = 1'b1
   } req_id_t;

   function automatic logic req_dir(input req_id_t id);
      return (id == REQ_PLAYER) ? DIR_UP : DIR_DOWN;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bullet_slot_picker.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : bullet_slot_picker
// Brief    : Priority encoder returning the lowest-index free bullet slot.
// Revision : 1.0  initial release
//==============================================================================
module bullet_slot_picker #(
   parameter int NUM_SLOTS = 4,
   parameter int SEL_W     = $clog2(NUM_SLOTS)
) (
   input  logic [NUM_SLOTS-1:0] slot_in_use,
   output logic [SEL_W-1:0]     sel,
   output logic                 any_free
);

   logic [NUM_SLOTS-1:0] w_free;

   assign w_free   = ~slot_in_use;
   assign any_free = |w_free;

   // Scan downwards so the lowest free index is the last one written.
   always_comb begin
      sel = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (w_free[i]) begin
            sel = SEL_W'(i);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/bullet_fire_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : bullet_fire_scheduler
// Brief    : Arbitrates player/enemy fire requests onto a shared bullet pool.
// Revision : 1.0  initial release
//==============================================================================
module bullet_fire_scheduler
   import bullet_pkg::*;
#(
   parameter int NUM_SLOTS       = 4,
   parameter int COOLDOWN_FRAMES = 8,
   parameter int CONFIRM_FRAMES  = 2
) (
   input  logic                 clk_60hz,
   input  logic                 reset,
   input  logic                 fire_player,
   input  logic                 fire_enemy,
   input  logic [9:0]           ship_x,
   input  logic [9:0]           enemy_x,
   input  logic [NUM_SLOTS-1:0] slot_in_use,
   output logic [NUM_SLOTS-1:0] start_bullet,
   output logic                 direction,
   output logic [9:0]           spawn_x,
   output logic                 grant_player,
   output logic                 grant_enemy,
   output logic                 spawn_fail,
   output logic [7:0]           shots_fired
);

   localparam int         SEL_W          = $clog2(NUM_SLOTS);
   localparam logic [7:0] C_COOLDOWN     = 8'(COOLDOWN_FRAMES);
   localparam logic [7:0] C_CONFIRM_LAST = 8'(CONFIRM_FRAMES - 1);

   fire_state_t          r_state;
   req_id_t              r_winner;
   req_id_t              r_rr_last;
   logic [SEL_W-1:0]     r_sel;
   logic [7:0]           r_wait;
   logic [7:0]           r_cool_player;
   logic [7:0]           r_cool_enemy;
   logic [NUM_SLOTS-1:0] r_start;
   logic                 r_direction;
   logic [9:0]           r_spawn_x;
   logic                 r_grant_player;
   logic                 r_grant_enemy;
   logic                 r_spawn_fail;
   logic [7:0]           r_shots;

   logic [SEL_W-1:0]     w_sel;
   logic                 w_any_free;
   logic                 w_player_ok;
   logic                 w_enemy_ok;
   req_id_t              w_winner;
   logic [NUM_SLOTS-1:0] w_onehot;

   bullet_slot_picker #(
      .NUM_SLOTS (NUM_SLOTS),
      .SEL_W     (SEL_W)
   ) u_picker (
      .slot_in_use (slot_in_use),
      .sel         (w_sel),
      .any_free    (w_any_free)
   );

   // A requester is ready on the frame its cooldown expires, so a held request
   // re-fires COOLDOWN_FRAMES+2 frames after its previous grant.
   assign w_player_ok = fire_player && (r_cool_player <= 8'd1);
   assign w_enemy_ok  = fire_enemy  && (r_cool_enemy  <= 8'd1);
   assign w_onehot    = NUM_SLOTS'(1) << w_sel;

   always_comb begin
      w_winner = REQ_PLAYER;
      if (w_player_ok && w_enemy_ok) begin
         w_winner = (r_rr_last == REQ_ENEMY) ? REQ_PLAYER : REQ_ENEMY;
      end else if (w_enemy_ok) begin
         w_winner = REQ_ENEMY;
      end
   end

   always_ff @(posedge clk_60hz) begin
      if (reset) begin
         r_state        <= IDLE;
         r_winner       <= REQ_PLAYER;
         r_rr_last      <= REQ_ENEMY;
         r_sel          <= '0;
         r_wait         <= '0;
         r_cool_player  <= '0;
         r_cool_enemy   <= '0;
         r_start        <= '0;
         r_direction    <= 1'b0;
         r_spawn_x      <= '0;
         r_grant_player <= 1'b0;
         r_grant_enemy  <= 1'b0;
         r_spawn_fail   <= 1'b0;
         r_shots        <= '0;
      end else begin
         r_start        <= '0;
         r_grant_player <= 1'b0;
         r_grant_enemy  <= 1'b0;
         r_spawn_fail   <= 1'b0;
         if (r_cool_player != 8'd0) r_cool_player <= r_cool_player - 8'd1;
         if (r_cool_enemy  != 8'd0) r_cool_enemy  <= r_cool_enemy  - 8'd1;

         case (r_state)
            IDLE: begin
               if ((w_player_ok || w_enemy_ok) && w_any_free) begin
                  r_winner    <= w_winner;
                  r_sel       <= w_sel;
                  r_start     <= w_onehot;
                  r_direction <= req_dir(w_winner);
                  r_spawn_x   <= (w_winner == REQ_PLAYER) ? ship_x : enemy_x;
                  r_state     <= ISSUE;
               end
            end
            ISSUE: begin
               r_wait  <= '0;
               r_state <= CONFIRM;
            end
            CONFIRM: begin
               if (slot_in_use[r_sel]) begin
                  if (r_winner == REQ_PLAYER) begin
                     r_grant_player <= 1'b1;
                     r_cool_player  <= C_COOLDOWN;
                  end else begin
                     r_grant_enemy <= 1'b1;
                     r_cool_enemy  <= C_COOLDOWN;
                  end
                  r_rr_last <= r_winner;
                  r_shots   <= r_shots + 8'd1;
                  r_state   <= IDLE;
               end else if (r_wait == C_CONFIRM_LAST) begin
                  r_spawn_fail <= 1'b1;
                  r_state      <= IDLE;
               end else begin
                  r_wait <= r_wait + 8'd1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Reset kills an in-flight start pulse in the frame it is raised.
   assign start_bullet = reset ? '0 : r_start;
   assign direction    = r_direction;
   assign spawn_x      = r_spawn_x;
   assign grant_player = r_grant_player;
   assign grant_enemy  = r_grant_enemy;
   assign spawn_fail   = r_spawn_fail;
   assign shots_fired  = r_shots;

endmodule
`default_nettype wire

// File: tb/tb_bullet_fire_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : tb_bullet_fire_scheduler
// Brief    : Scoreboard bench for bullet_fire_scheduler with a bullet-pool model.
// Revision : 1.0  initial release
//==============================================================================
module tb_bullet_fire_scheduler;

   localparam int NUM_SLOTS       = 4;
   localparam int COOLDOWN_FRAMES = 8;
   localparam int CONFIRM_FRAMES  = 2;
   localparam logic [2:0] EV_GP   = 3'b001;
   localparam logic [2:0] EV_GE   = 3'b010;
   localparam logic [2:0] EV_FAIL = 3'b100;

   typedef struct packed {
      logic [3:0] start;
      logic       dir;
      logic [9:0] x;
   } exp_start_t;

   logic                 clk_60hz = 1'b0;
   logic                 reset;
   logic                 fire_player;
   logic                 fire_enemy;
   logic [9:0]           ship_x;
   logic [9:0]           enemy_x;
   logic [NUM_SLOTS-1:0] slot_in_use;
   logic [NUM_SLOTS-1:0] start_bullet;
   logic                 direction;
   logic [9:0]           spawn_x;
   logic                 grant_player;
   logic                 grant_enemy;
   logic                 spawn_fail;
   logic [7:0]           shots_fired;

   int         total = 0;
   int         bad   = 0;
   int         fr    = 0;
   logic [3:0] pend;
   bit         ack;
   bit         short_life;
   logic [7:0] exp_shots;
   exp_start_t exp_start_q[$];
   logic [2:0] exp_ev_q[$];
   int         sframes[$];
   int         evframes[$];
   int         r0;

   bullet_fire_scheduler #(
      .NUM_SLOTS       (NUM_SLOTS),
      .COOLDOWN_FRAMES (COOLDOWN_FRAMES),
      .CONFIRM_FRAMES  (CONFIRM_FRAMES)
   ) dut (
      .clk_60hz     (clk_60hz),
      .reset        (reset),
      .fire_player  (fire_player),
      .fire_enemy   (fire_enemy),
      .ship_x       (ship_x),
      .enemy_x      (enemy_x),
      .slot_in_use  (slot_in_use),
      .start_bullet (start_bullet),
      .direction    (direction),
      .spawn_x      (spawn_x),
      .grant_player (grant_player),
      .grant_enemy  (grant_enemy),
      .spawn_fail   (spawn_fail),
      .shots_fired  (shots_fired)
   );

   always #5 clk_60hz = ~clk_60hz;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic exp_start_t mk(input logic [3:0] s, input logic d, input logic [9:0] x);
      exp_start_t e;
      e.start = s;
      e.dir   = d;
      e.x     = x;
      return e;
   endfunction

   // One frame: advance, update the bullet model, then score DUT outputs.
   task automatic frame();
      exp_start_t e;
      logic [2:0] ev;
      logic [2:0] want;
      @(posedge clk_60hz);
      #1;
      fr++;
      slot_in_use = short_life ? pend : (slot_in_use | pend);
      pend = '0;
      if (start_bullet != '0) begin
         sframes.push_back(fr);
         if (exp_start_q.size() == 0) begin
            chk("unexpected_start", 32'(start_bullet), 32'd0);
         end else begin
            e = exp_start_q.pop_front();
            chk("start_bullet", 32'(start_bullet), 32'(e.start));
            chk("direction", 32'(direction), 32'(e.dir));
            chk("spawn_x", 32'(spawn_x), 32'(e.x));
         end
         if (ack) pend = start_bullet;
      end
      ev = {spawn_fail, grant_enemy, grant_player};
      if (ev != 3'b000) begin
         evframes.push_back(fr);
         if (exp_ev_q.size() == 0) begin
            chk("unexpected_event", 32'(ev), 32'd0);
         end else begin
            want = exp_ev_q.pop_front();
            chk("event", 32'(ev), 32'(want));
            if (want != EV_FAIL) exp_shots = exp_shots + 8'd1;
            chk("shots_fired", 32'(shots_fired), 32'(exp_shots));
         end
      end
   endtask

   task automatic run_drain(input int max_frames, input string tag);
      int n = 0;
      while ((exp_start_q.size() + exp_ev_q.size()) != 0 && n < max_frames) begin
         frame();
         n++;
      end
      chk({"drain_", tag}, 32'(exp_start_q.size() + exp_ev_q.size()), 32'd0);
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      fire_player = 1'b0;
      fire_enemy  = 1'b0;
      slot_in_use = '0;
      pend        = '0;
      ack         = 1'b1;
      short_life  = 1'b0;
      exp_shots   = '0;
      exp_start_q.delete();
      exp_ev_q.delete();
      sframes.delete();
      evframes.delete();
      frame();
      frame();
      reset = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      ship_x  = '0;
      enemy_x = '0;
      do_reset();

      // Reset state
      chk("rst_start", 32'(start_bullet), 32'd0);
      chk("rst_direction", 32'(direction), 32'd0);
      chk("rst_spawn_x", 32'(spawn_x), 32'd0);
      chk("rst_grant_player", 32'(grant_player), 32'd0);
      chk("rst_grant_enemy", 32'(grant_enemy), 32'd0);
      chk("rst_spawn_fail", 32'(spawn_fail), 32'd0);
      chk("rst_shots", 32'(shots_fired), 32'd0);

      // Held player fire fills slots lowest-first at the cooldown rate
      ship_x      = 10'd100;
      fire_player = 1'b1;
      r0          = fr;
      for (int k = 0; k < NUM_SLOTS; k++) begin
         exp_start_q.push_back(mk(4'(1 << k), 1'b1, 10'd100));
         exp_ev_q.push_back(EV_GP);
      end
      run_drain(80, "player_fill");
      chk("first_start_latency", 32'(sframes[0] - r0), 32'd1);
      chk("first_grant_latency", 32'(evframes[0] - r0), 32'd3);
      for (int i = 1; i < NUM_SLOTS; i++) begin
         chk("grant_spacing", 32'(evframes[i] - evframes[i-1]), 32'(COOLDOWN_FRAMES + 2));
      end

      // Pool full: no start; then free slot 2 with a new ship X
      repeat (20) frame();
      ship_x         = 10'd300;
      slot_in_use[2] = 1'b0;
      exp_start_q.push_back(mk(4'b0100, 1'b1, 10'd300));
      exp_ev_q.push_back(EV_GP);
      run_drain(20, "slot2");
      fire_player = 1'b0;

      // Both requesting from reset: player wins first tie, then alternating
      do_reset();
      ship_x      = 10'd111;
      enemy_x     = 10'd222;
      fire_player = 1'b1;
      fire_enemy  = 1'b1;
      exp_start_q.push_back(mk(4'b0001, 1'b1, 10'd111)); exp_ev_q.push_back(EV_GP);
      exp_start_q.push_back(mk(4'b0010, 1'b0, 10'd222)); exp_ev_q.push_back(EV_GE);
      exp_start_q.push_back(mk(4'b0100, 1'b1, 10'd111)); exp_ev_q.push_back(EV_GP);
      exp_start_q.push_back(mk(4'b1000, 1'b0, 10'd222)); exp_ev_q.push_back(EV_GE);
      run_drain(80, "alternate");
      fire_player = 1'b0;
      fire_enemy  = 1'b0;

      // Tie after a player grant goes to the enemy
      do_reset();
      ship_x      = 10'd50;
      fire_player = 1'b1;
      exp_start_q.push_back(mk(4'b0001, 1'b1, 10'd50)); exp_ev_q.push_back(EV_GP);
      run_drain(10, "rr_prime");
      fire_player = 1'b0;
      repeat (12) frame();
      enemy_x     = 10'd600;
      fire_player = 1'b1;
      fire_enemy  = 1'b1;
      exp_start_q.push_back(mk(4'b0010, 1'b0, 10'd600)); exp_ev_q.push_back(EV_GE);
      exp_start_q.push_back(mk(4'b0100, 1'b1, 10'd50));  exp_ev_q.push_back(EV_GP);
      run_drain(40, "rr_tie");
      fire_player = 1'b0;
      fire_enemy  = 1'b0;

      // Slot never acknowledges: spawn_fail, no cooldown, immediate retry
      do_reset();
      ack        = 1'b0;
      enemy_x    = 10'd500;
      fire_enemy = 1'b1;
      exp_start_q.push_back(mk(4'b0001, 1'b0, 10'd500)); exp_ev_q.push_back(EV_FAIL);
      exp_start_q.push_back(mk(4'b0001, 1'b0, 10'd500)); exp_ev_q.push_back(EV_FAIL);
      run_drain(30, "spawn_fail");
      fire_enemy = 1'b0;
      chk("fail_latency", 32'(evframes[0] - sframes[0]), 32'(CONFIRM_FRAMES + 1));
      chk("retry_gap", 32'(sframes[1] - evframes[0]), 32'd1);
      chk("fail_shots", 32'(shots_fired), 32'd0);

      // Reset raised during ISSUE drops the start pulse in that frame
      do_reset();
      ship_x      = 10'd77;
      fire_player = 1'b1;
      exp_start_q.push_back(mk(4'b0001, 1'b1, 10'd77));
      run_drain(5, "issue");
      reset = 1'b1;
      #1;
      chk("reset_in_issue", 32'(start_bullet), 32'd0);
      do_reset();
      chk("post_reset_shots", 32'(shots_fired), 32'd0);

      // 256 confirmed shots wrap the counter back to zero
      do_reset();
      short_life  = 1'b1;
      ship_x      = 10'd10;
      enemy_x     = 10'd20;
      fire_player = 1'b1;
      fire_enemy  = 1'b1;
      for (int i = 0; i < 256; i++) begin
         if (i % 2 == 0) begin
            exp_start_q.push_back(mk(4'b0001, 1'b1, 10'd10));
            exp_ev_q.push_back(EV_GP);
         end else begin
            exp_start_q.push_back(mk(4'b0001, 1'b0, 10'd20));
            exp_ev_q.push_back(EV_GE);
         end
      end
      run_drain(3000, "wrap");
      fire_player = 1'b0;
      fire_enemy  = 1'b0;
      chk("wrap_shots", 32'(shots_fired), 32'd0);
      repeat (3) frame();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
